// File: rtl/fx_kp_pkg.sv
// Shared constants and state type for the PC-FX K-port pad-side link.
package fx_kp_pkg;

    localparam int         KP_BITS   = 32;
    localparam logic [3:0] KP_ID_PAD = 4'hF;

    typedef enum logic [1:0] {
        KP_IDLE,
        KP_SHIFT,
        KP_DONE
    } kp_state_t;

endpackage

// File: rtl/fx_kp_edge.sv
// Edge detector for one K-port input; FX_PAD_KP_SYNC_EN adds a 2-flop CE-gated synchronizer.
module fx_kp_edge
    import fx_kp_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic ce,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef FX_PAD_KP_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (res) begin
            sync <= 2'b00;
        end else if (ce) begin
            sync <= {sync[0], d};
        end
    end

    assign level = sync[1];
`else
    assign level = d;
`endif

    logic prev;

    always_ff @(posedge clk) begin
        if (res) begin
            prev <= 1'b0;
        end else if (ce) begin
            prev <= level;
        end
    end

    // Edges are only meaningful in cycles where state may advance.
    assign rise = ce &  level & ~prev;
    assign fall = ce & ~level &  prev;

endmodule

// File: rtl/fx_pad_kp.sv
// Pad-side end of the PC-FX K-port serial link, emulating one controller.
// Define FX_PAD_KP_SYNC_EN to synchronize the host-side inputs (+2 CE cycles latency).
module fx_pad_kp
    import fx_kp_pkg::*;
#(
    parameter int BITS     = KP_BITS,
    parameter bit FORCE_ID = 1'b1
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            CE,
    input  logic            CONNECTED,
    input  logic [BITS-1:0] PAD_DATA,
    input  logic            KP_LATCH,
    input  logic            KP_CLK,
    input  logic            KP_RW,
    input  logic            KP_DOUT,
    output logic            KP_DIN,
    output logic [BITS-1:0] RX_DATA,
    output logic            RX_VALID,
    output logic            BUSY
);

    localparam int CNT_W = $clog2(BITS + 1);

    logic latch_rise, clk_rise, clk_fall, rw_lvl, dout_lvl;
    logic latch_lvl_unused, latch_fall_unused, clk_lvl_unused;
    logic rw_rise_unused, rw_fall_unused, dout_rise_unused, dout_fall_unused;

    fx_kp_edge u_latch (.clk(CLK), .res(RES), .ce(CE), .d(KP_LATCH),
                        .level(latch_lvl_unused), .rise(latch_rise), .fall(latch_fall_unused));
    fx_kp_edge u_clk   (.clk(CLK), .res(RES), .ce(CE), .d(KP_CLK),
                        .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall));
    fx_kp_edge u_rw    (.clk(CLK), .res(RES), .ce(CE), .d(KP_RW),
                        .level(rw_lvl), .rise(rw_rise_unused), .fall(rw_fall_unused));
    fx_kp_edge u_dout  (.clk(CLK), .res(RES), .ce(CE), .d(KP_DOUT),
                        .level(dout_lvl), .rise(dout_rise_unused), .fall(dout_fall_unused));

    kp_state_t        state, state_next;
    logic [BITS-1:0]  sr, sr_shift, report;
    logic [CNT_W-1:0] count, count_inc;
    logic             rw_mode, mixed, mixed_now, rx_bit;
    logic             do_load, do_shift, do_cap, finish;

    assign report    = FORCE_ID ? {KP_ID_PAD, PAD_DATA[BITS-5:0]} : PAD_DATA;
    assign sr_shift  = {rx_bit, sr[BITS-1:1]};
    assign count_inc = count + 1'b1;
    assign mixed_now = mixed | (rw_lvl != rw_mode);

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_cap     = 1'b0;
        finish     = 1'b0;
        // A latch rise restarts the frame from any state and masks a same-cycle clock rise.
        if (latch_rise) begin
            do_load    = 1'b1;
            state_next = KP_SHIFT;
        end else if (state == KP_SHIFT) begin
            do_cap = clk_fall;
            if (clk_rise) begin
                do_shift = 1'b1;
                if (count_inc == CNT_W'(BITS)) begin
                    finish     = 1'b1;
                    state_next = KP_DONE;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state <= KP_IDLE;
        end else if (CE) begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            sr       <= '0;
            count    <= '0;
            rw_mode  <= 1'b0;
            mixed    <= 1'b0;
            rx_bit   <= 1'b0;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
        end else if (CE) begin
            RX_VALID <= 1'b0;
            if (do_load) begin
                sr      <= report;
                count   <= '0;
                rw_mode <= rw_lvl;
                mixed   <= 1'b0;
            end else if (state == KP_SHIFT) begin
                mixed <= mixed_now;
                if (do_cap) begin
                    rx_bit <= ~dout_lvl;
                end
                if (do_shift) begin
                    sr    <= sr_shift;
                    count <= count_inc;
                    // Only a clean, connected host->pad frame publishes its data.
                    if (finish && rw_mode && !mixed_now && CONNECTED) begin
                        RX_DATA  <= sr_shift;
                        RX_VALID <= 1'b1;
                    end
                end
            end
        end
    end

    logic unused_edges;
    assign unused_edges = ^{latch_lvl_unused, latch_fall_unused, clk_lvl_unused,
                            rw_rise_unused, rw_fall_unused, dout_rise_unused, dout_fall_unused};

    assign BUSY   = (state == KP_SHIFT);
    assign KP_DIN = KP_RW | ~sr[0] | ~CONNECTED;

endmodule

// File: tb/tb_fx_pad_kp.sv
// Directed, scoreboard-based bench for fx_pad_kp; works with or without FX_PAD_KP_SYNC_EN.
module tb_fx_pad_kp;

`ifdef FX_PAD_KP_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        res, ce, connected, kp_latch, kp_clk, kp_rw, kp_dout;
    logic [31:0] pad_data;
    logic        kp_din, rx_valid, busy;
    logic [31:0] rx_data;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rv_count = 0;
    logic [31:0] exp_q[$];

    fx_pad_kp #(.BITS(32), .FORCE_ID(1'b1)) dut (
        .CLK(clk), .RES(res), .CE(ce), .CONNECTED(connected), .PAD_DATA(pad_data),
        .KP_LATCH(kp_latch), .KP_CLK(kp_clk), .KP_RW(kp_rw), .KP_DOUT(kp_dout),
        .KP_DIN(kp_din), .RX_DATA(rx_data), .RX_VALID(rx_valid), .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: observed %h expected <none queued>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            chk(tag, obs, expv);
        end
    endtask

    // Each RX_VALID pulse is matched against the oldest queued host->pad frame.
    always @(negedge clk) begin
        if (ce && rx_valid) begin
            rv_count++;
            sb_check("rx_frame", rx_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pulse();
        kp_latch = 1'b1; tick(4);
        kp_latch = 1'b0; tick(4);
    endtask

    task automatic host_bit(input logic dout_v, output logic din_seen);
        din_seen = kp_din;
        kp_clk = 1'b0; kp_dout = dout_v; tick(4);
        kp_clk = 1'b1; tick(4);
    endtask

    task automatic read_word(input int nbits, output logic [31:0] word);
        logic d;
        word = '0;
        for (int i = 0; i < nbits; i++) begin
            host_bit(1'b1, d);
            word[i] = ~d;
        end
    endtask

    initial begin
        logic [31:0] word, tx;
        logic        d, din_all;

        res = 1'b1; ce = 1'b1; connected = 1'b1; pad_data = '0;
        kp_latch = 1'b0; kp_clk = 1'b1; kp_rw = 1'b0; kp_dout = 1'b1;
        tick(3);
        res = 1'b0;
        tick(1);
        chk("reset_din", kp_din, 1);
        chk("reset_busy", busy, 0);
        chk("reset_valid", rx_valid, 0);
        chk("reset_rxdata", rx_data, 32'h0);

        // Clock-enable low freezes edge detection; the latch is seen once CE returns.
        ce = 1'b0; pad_data = 32'h0000_12A5; kp_latch = 1'b1;
        tick(4);
        chk("ce_low_busy", busy, 0);
        ce = 1'b1;
        tick(LAT);
        chk("latch_latency_pre", busy, 0);
        tick(1);
        chk("latch_latency_post", busy, 1);
        kp_latch = 1'b0; tick(4);

        // Pad->host frame with forced ID nibble.
        chk("p2h_bit0", kp_din, 0);
        exp_q.push_back(32'hF000_12A5);
        read_word(32, word);
        sb_check("p2h_word", word);
        chk("p2h_done_busy", busy, 0);
        chk("p2h_no_valid", rv_count, 0);

        // Host->pad frame.
        kp_rw = 1'b1; tick(4);
        latch_pulse();
        tx = 32'hCDEF1234;
        exp_q.push_back(tx);
        din_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            host_bit(~tx[i], d);
            din_all = din_all & d;
        end
        tick(4);
        chk("h2p_din_high", din_all, 1);
        chk("h2p_valid_count", rv_count, 1);
        chk("h2p_rxdata", rx_data, 32'hCDEF1234);
        chk("h2p_done_busy", busy, 0);

        // Relatch mid-frame restarts the count.
        kp_rw = 1'b0; tick(4);
        latch_pulse();
        read_word(10, word);
        pad_data = 32'h0000_0001;
        latch_pulse();
        chk("relatch_bit0", kp_din, 0);
        exp_q.push_back(32'hF000_0001);
        read_word(31, word);
        chk("relatch_busy_31", busy, 1);
        host_bit(1'b1, d);
        word[31] = ~d;
        chk("relatch_busy_32", busy, 0);
        sb_check("relatch_word", word);

        // Host->pad frame with KP_RW toggled at bit 16: no publish.
        kp_rw = 1'b1; tick(4);
        latch_pulse();
        tx = 32'hA5A5_0F0F;
        for (int i = 0; i < 32; i++) begin
            if (i == 16) kp_rw = 1'b0;
            host_bit(~tx[i], d);
            if (i == 16) kp_rw = 1'b1;
        end
        for (int i = 0; i < 5; i++) host_bit(1'b0, d);
        chk("mixed_valid_count", rv_count, 1);
        chk("mixed_rxdata", rx_data, 32'hCDEF1234);
        chk("mixed_busy", busy, 0);

        // Pad disconnects during a pad->host frame.
        kp_rw = 1'b0; tick(4);
        pad_data = 32'h0000_FFFF;
        latch_pulse();
        chk("conn_bit0", kp_din, 0);
        connected = 1'b0;
        #1;
        chk("disconn_din", kp_din, 1);
        exp_q.push_back(32'h0);
        read_word(32, word);
        sb_check("disconn_word", word);
        chk("disconn_busy", busy, 0);
        connected = 1'b1;

        // Reset mid-frame.
        latch_pulse();
        read_word(10, word);
        chk("midres_busy_pre", busy, 1);
        res = 1'b1; tick(1); res = 1'b0;
        chk("midres_busy", busy, 0);
        chk("midres_din", kp_din, 1);
        chk("midres_rxdata", rx_data, 32'h0);
        chk("midres_valid", rx_valid, 0);
        tick(2);
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
